// File: rtl/sdram_arbiter_if.sv
// Application-side bus between the arbiter (master) and the SDRAM core (slave).
interface sdram_arbiter_if;
    logic        sdram_ready;
    logic        write_fifo_full;
    logic        read_fifo_empty;
    logic [31:0] app_read_data;
    logic        app_write_enable;
    logic        app_read_enable;
    logic [21:0] app_address;
    logic        app_write_pulse;
    logic [31:0] app_write_data;
    logic [3:0]  app_write_mask;
    logic        app_read_pulse;

    modport master (
        input  sdram_ready, write_fifo_full, read_fifo_empty, app_read_data,
        output app_write_enable, app_read_enable, app_address,
               app_write_pulse, app_write_data, app_write_mask, app_read_pulse
    );

    modport slave (
        output sdram_ready, write_fifo_full, read_fifo_empty, app_read_data,
        input  app_write_enable, app_read_enable, app_address,
               app_write_pulse, app_write_data, app_write_mask, app_read_pulse
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM core application interface;
// each grant runs one fixed-length read or write transaction to completion.
module sdram_arbiter #(
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned DRAIN_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_arbiter_if.master      core,
    input  logic                 p0_req,
    input  logic                 p0_write,
    input  logic [21:0]          p0_address,
    input  logic [LEN_WIDTH-1:0] p0_length,
    output logic                 p0_grant,
    output logic                 p0_done,
    input  logic                 p0_wr_strobe,
    input  logic [31:0]          p0_wr_data,
    input  logic [3:0]           p0_wr_mask,
    output logic                 p0_wr_ready,
    input  logic                 p0_rd_ready,
    output logic                 p0_rd_strobe,
    output logic [31:0]          p0_rd_data,
    input  logic                 p1_req,
    input  logic                 p1_write,
    input  logic [21:0]          p1_address,
    input  logic [LEN_WIDTH-1:0] p1_length,
    output logic                 p1_grant,
    output logic                 p1_done,
    input  logic                 p1_wr_strobe,
    input  logic [31:0]          p1_wr_data,
    input  logic [3:0]           p1_wr_mask,
    output logic                 p1_wr_ready,
    input  logic                 p1_rd_ready,
    output logic                 p1_rd_strobe,
    output logic [31:0]          p1_rd_data
);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WRITE, S_DRAIN, S_READ, S_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 write_q, write_d;
    logic [21:0]          addr_q, addr_d;
    logic [21:0]          app_addr_q, app_addr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 last_q, last_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           done_q, done_d;
    logic                 rd_strobe_q, rd_strobe_d;
    logic                 wen_q, wen_d;
    logic                 ren_q, ren_d;

    logic wr_ready_c, wr_strobe_c, rd_ready_c, wr_pulse_c, rd_pulse_c, pick_c;

    // Next-state, datapath counters and the combinational FIFO handshakes.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        write_d    = write_q;
        addr_d     = addr_q;
        app_addr_d = app_addr_q;
        len_d      = len_q;
        count_d    = count_q;
        drain_d    = drain_q;
        last_d     = last_q;
        grant_d    = grant_q;
        done_d     = 2'b00;
        pick_c     = 1'b0;

        wr_strobe_c = sel_q ? p1_wr_strobe : p0_wr_strobe;
        rd_ready_c  = sel_q ? p1_rd_ready  : p0_rd_ready;
        // Handshakes are gated by sdram_ready so nothing moves in an aborting cycle.
        wr_ready_c  = (state_q == S_WRITE) && core.sdram_ready &&
                      !core.write_fifo_full && (count_q < len_q);
        wr_pulse_c  = wr_ready_c && wr_strobe_c;
        rd_pulse_c  = (state_q == S_READ) && core.sdram_ready &&
                      !core.read_fifo_empty && rd_ready_c && (count_q < len_q);

        case (state_q)
            S_IDLE: begin
                if (core.sdram_ready && (p0_req || p1_req)) begin
                    pick_c  = (p0_req && p1_req) ? ~last_q : p1_req;
                    sel_d   = pick_c;
                    write_d = pick_c ? p1_write   : p0_write;
                    addr_d  = pick_c ? p1_address : p0_address;
                    len_d   = pick_c ? p1_length  : p0_length;
                    grant_d = pick_c ? 2'b10 : 2'b01;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                app_addr_d = addr_q;
                count_d    = '0;
                if (len_q == '0)  state_d = S_RELEASE;
                else if (write_q) state_d = S_WRITE;
                else              state_d = S_READ;
            end
            S_WRITE: begin
                if (wr_pulse_c) begin
                    count_d = count_q + LEN_WIDTH'(1);
                    if (count_d == len_q) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = S_RELEASE;
                else drain_d = drain_q + DRAIN_W'(1);
            end
            S_READ: begin
                if (rd_pulse_c) count_d = count_q + LEN_WIDTH'(1);
                // Final word is being delivered this cycle.
                if (rd_strobe_q && (count_q == len_q)) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                grant_d = 2'b00;
                done_d  = sel_q ? 2'b10 : 2'b01;
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Loss of sdram_ready abandons the transaction silently.
        if ((state_q != S_IDLE) && !core.sdram_ready) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            done_d  = 2'b00;
            last_d  = last_q;
        end

        wen_d       = (state_d == S_WRITE) || (state_d == S_DRAIN);
        ren_d       = (state_d == S_READ);
        rd_strobe_d = rd_pulse_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            app_addr_q  <= '0;
            len_q       <= '0;
            count_q     <= '0;
            drain_q     <= '0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            rd_strobe_q <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            app_addr_q  <= app_addr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            rd_strobe_q <= rd_strobe_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
        end
    end

    assign core.app_write_enable = wen_q;
    assign core.app_read_enable  = ren_q;
    assign core.app_address      = app_addr_q;
    assign core.app_write_pulse  = wr_pulse_c;
    assign core.app_write_data   = sel_q ? p1_wr_data : p0_wr_data;
    assign core.app_write_mask   = sel_q ? p1_wr_mask : p0_wr_mask;
    assign core.app_read_pulse   = rd_pulse_c;

    // Core read data is valid the cycle after the pop, alongside the strobe.
    assign p0_grant     = grant_q[0];
    assign p0_done      = done_q[0];
    assign p0_wr_ready  = wr_ready_c && !sel_q;
    assign p0_rd_strobe = rd_strobe_q && !sel_q;
    assign p0_rd_data   = p0_rd_strobe ? core.app_read_data : 32'h0;

    assign p1_grant     = grant_q[1];
    assign p1_done      = done_q[1];
    assign p1_wr_ready  = wr_ready_c && sel_q;
    assign p1_rd_strobe = rd_strobe_q && sel_q;
    assign p1_rd_data   = p1_rd_strobe ? core.app_read_data : 32'h0;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: transaction vector table plus hand-written
// contention, backpressure and abort sequences.
module tb_sdram_arbiter;
    localparam int unsigned LEN_WIDTH = 16;
    localparam int unsigned DRAIN     = 64;

    logic clk;
    logic rst;
    sdram_arbiter_if core_if();

    logic                 p0_req, p0_write, p0_grant, p0_done, p0_wr_strobe, p0_wr_ready;
    logic                 p0_rd_ready, p0_rd_strobe;
    logic [21:0]          p0_address;
    logic [LEN_WIDTH-1:0] p0_length;
    logic [31:0]          p0_wr_data, p0_rd_data;
    logic [3:0]           p0_wr_mask;
    logic                 p1_req, p1_write, p1_grant, p1_done, p1_wr_strobe, p1_wr_ready;
    logic                 p1_rd_ready, p1_rd_strobe;
    logic [21:0]          p1_address;
    logic [LEN_WIDTH-1:0] p1_length;
    logic [31:0]          p1_wr_data, p1_rd_data;
    logic [3:0]           p1_wr_mask;

    sdram_arbiter #(.LEN_WIDTH(LEN_WIDTH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .core(core_if),
        .p0_req(p0_req), .p0_write(p0_write), .p0_address(p0_address), .p0_length(p0_length),
        .p0_grant(p0_grant), .p0_done(p0_done), .p0_wr_strobe(p0_wr_strobe),
        .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask), .p0_wr_ready(p0_wr_ready),
        .p0_rd_ready(p0_rd_ready), .p0_rd_strobe(p0_rd_strobe), .p0_rd_data(p0_rd_data),
        .p1_req(p1_req), .p1_write(p1_write), .p1_address(p1_address), .p1_length(p1_length),
        .p1_grant(p1_grant), .p1_done(p1_done), .p1_wr_strobe(p1_wr_strobe),
        .p1_wr_data(p1_wr_data), .p1_wr_mask(p1_wr_mask), .p1_wr_ready(p1_wr_ready),
        .p1_rd_ready(p1_rd_ready), .p1_rd_strobe(p1_rd_strobe), .p1_rd_data(p1_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        bit          wr;
        logic [21:0] addr;
        int          len;
        bit          spor;
        int          exp_wp;
        int          exp_rp;
        int          exp_wen;
        int          exp_ren;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    bit   sporadic = 1'b0;

    // Running observation counters; every cycle is also screened for protocol breaks.
    int          n_wp = 0, n_rp = 0, n_st = 0, n_wen = 0, n_ren = 0, n_d0 = 0, n_d1 = 0;
    int          viol = 0, en_rise = 0;
    logic [21:0] addr_seen = 22'h0;
    bit          pop_prev = 1'b0, en_prev = 1'b0, g0_prev = 1'b0, g1_prev = 1'b0;
    int          gq[$];

    always @(negedge clk) begin
        if (rst) begin
            pop_prev = 1'b0; en_prev = 1'b0; g0_prev = 1'b0; g1_prev = 1'b0;
        end else begin
            if (core_if.app_write_pulse)  n_wp++;
            if (core_if.app_read_pulse)   n_rp++;
            if (p0_rd_strobe || p1_rd_strobe) n_st++;
            if (core_if.app_write_enable) n_wen++;
            if (core_if.app_read_enable)  n_ren++;
            if (p0_done) n_d0++;
            if (p1_done) n_d1++;
            if (core_if.app_write_enable && core_if.app_read_enable) viol++;
            if (p0_grant && p1_grant) viol++;
            if ((core_if.app_write_enable || core_if.app_read_enable) && !(p0_grant || p1_grant)) viol++;
            if (!p0_grant && (p0_wr_ready || p0_rd_strobe)) viol++;
            if (!p1_grant && (p1_wr_ready || p1_rd_strobe)) viol++;
            if ((p0_rd_strobe || p1_rd_strobe) != pop_prev) viol++;
            if (p0_rd_strobe && (p0_rd_data != core_if.app_read_data)) viol++;
            if (p1_rd_strobe && (p1_rd_data != core_if.app_read_data)) viol++;
            if (core_if.app_write_pulse &&
                ((core_if.app_write_data != (p1_grant ? p1_wr_data : p0_wr_data)) ||
                 (core_if.app_write_mask != (p1_grant ? p1_wr_mask : p0_wr_mask)))) viol++;
            if ((core_if.app_write_enable || core_if.app_read_enable) && !en_prev) en_rise = cyc;
            if (core_if.app_write_enable || core_if.app_read_enable) addr_seen = core_if.app_address;
            if (p0_grant && !g0_prev) gq.push_back(0);
            if (p1_grant && !g1_prev) gq.push_back(1);
            pop_prev = core_if.app_read_pulse;
            en_prev  = core_if.app_write_enable || core_if.app_read_enable;
            g0_prev  = p0_grant;
            g1_prev  = p1_grant;
        end
    end

    // Read-side core model: fresh data every cycle, optionally a flaky empty flag.
    initial begin
        core_if.read_fifo_empty = 1'b0;
        core_if.app_read_data   = 32'h0;
        forever begin
            @(posedge clk); #1;
            core_if.app_read_data   = $urandom;
            core_if.read_fifo_empty = sporadic ? ($urandom_range(0, 2) != 0) : 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_port(input bit p, input bit req, input bit wr,
                              input logic [21:0] a, input int len);
        if (p) begin
            p1_req = req; p1_write = wr; p1_address = a; p1_length = LEN_WIDTH'(len);
        end else begin
            p0_req = req; p0_write = wr; p0_address = a; p0_length = LEN_WIDTH'(len);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int b_wp, b_rp, b_st, b_wen, b_ren, b_d0, b_d1, b_viol, rc, gc, dc;
        bit got;
        @(posedge clk); #1;
        sporadic = v.spor;
        b_wp = n_wp; b_rp = n_rp; b_st = n_st; b_wen = n_wen; b_ren = n_ren;
        b_d0 = n_d0; b_d1 = n_d1; b_viol = viol;
        drive_port(v.port, 1'b1, v.wr, v.addr, v.len);
        rc = cyc; gc = 0; dc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((v.port ? p1_grant : p0_grant) == 1'b1) begin got = 1'b1; gc = cyc; end
        end
        @(posedge clk); #1;
        drive_port(v.port, 1'b0, v.wr, v.addr, v.len);
        check_eq($sformatf("v%0d_grant_latency", idx), got ? (gc - rc) : -1, 1);
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if ((v.port ? p1_done : p0_done) == 1'b1) begin got = 1'b1; dc = cyc; end
        end
        @(posedge clk); #1;
        sporadic = 1'b0;
        check_eq($sformatf("v%0d_done_seen", idx), int'(got), 1);
        if (v.exp_lat >= 0) check_eq($sformatf("v%0d_done_latency", idx), dc - gc, v.exp_lat);
        check_eq($sformatf("v%0d_write_pulses", idx), n_wp - b_wp, v.exp_wp);
        check_eq($sformatf("v%0d_read_pops", idx), n_rp - b_rp, v.exp_rp);
        check_eq($sformatf("v%0d_rd_strobes", idx), n_st - b_st, v.exp_rp);
        check_eq($sformatf("v%0d_wen_cycles", idx), n_wen - b_wen, v.exp_wen);
        if (v.exp_ren >= 0) check_eq($sformatf("v%0d_ren_cycles", idx), n_ren - b_ren, v.exp_ren);
        check_eq($sformatf("v%0d_done_p0", idx), n_d0 - b_d0, v.port ? 0 : 1);
        check_eq($sformatf("v%0d_done_p1", idx), n_d1 - b_d1, v.port ? 1 : 0);
        check_eq($sformatf("v%0d_protocol", idx), viol - b_viol, 0);
        if (v.len > 0) begin
            check_eq($sformatf("v%0d_enable_rise", idx), en_rise - rc, 2);
            check_eq($sformatf("v%0d_app_address", idx), addr_seen, v.addr);
        end
    endtask

    initial begin
        int gbase, b_wp, b_wen, b_d0, b_d1, bp_bad, cnt;
        bit got;

        // port, wr, addr, len, sporadic, exp pulses, pops, wen cycles, ren cycles, done latency
        vecs[0] = '{1'b0, 1'b1, 22'h000100, 4, 1'b0, 4, 0, 68, 0, 70};
        vecs[1] = '{1'b1, 1'b0, 22'h2AAAAA, 3, 1'b1, 0, 3, 0, -1, -1};
        vecs[2] = '{1'b0, 1'b1, 22'h000040, 0, 1'b0, 0, 0, 0, 0, 2};
        vecs[3] = '{1'b1, 1'b1, 22'h3FFFFF, 1, 1'b0, 1, 0, 65, 0, 67};
        vecs[4] = '{1'b0, 1'b0, 22'h012345, 5, 1'b0, 0, 5, 0, 6, 8};
        vecs[5] = '{1'b1, 1'b0, 22'h000000, 0, 1'b0, 0, 0, 0, 0, 2};
        vecs[6] = '{1'b1, 1'b1, 22'h001000, 2, 1'b0, 2, 0, 66, 0, 68};

        rst = 1'b1;
        core_if.sdram_ready     = 1'b1;
        core_if.write_fifo_full = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, 22'h0, 0);
        drive_port(1'b1, 1'b0, 1'b0, 22'h0, 0);
        p0_wr_strobe = 1'b1; p0_wr_data = 32'hA0A0_5A5A; p0_wr_mask = 4'h3; p0_rd_ready = 1'b1;
        p1_wr_strobe = 1'b1; p1_wr_data = 32'hB1B1_C3C3; p1_wr_mask = 4'hC; p1_rd_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_wen", core_if.app_write_enable, 0);
        check_eq("reset_ren", core_if.app_read_enable, 0);
        check_eq("reset_address", core_if.app_address, 0);
        check_eq("reset_grants", {p1_grant, p0_grant}, 0);
        check_eq("reset_done", {p1_done, p0_done}, 0);
        check_eq("reset_rd_strobe", {p1_rd_strobe, p0_rd_strobe}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: both ports keep requesting zero-length writes.
        @(posedge clk); #1;
        gbase = gq.size();
        drive_port(1'b0, 1'b1, 1'b1, 22'h000010, 0);
        drive_port(1'b1, 1'b1, 1'b1, 22'h000020, 0);
        for (int i = 0; i < 100 && gq.size() < gbase + 4; i++) @(negedge clk);
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b1, 22'h000010, 0);
        drive_port(1'b1, 1'b0, 1'b1, 22'h000020, 0);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("contention_grant%0d", k),
                     (gq.size() > gbase + k) ? gq[gbase + k] : -1, k % 2);
        repeat (8) @(posedge clk);

        for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

        // Backpressure: write_fifo_full for 5 cycles after the third word.
        @(posedge clk); #1;
        b_wp = n_wp; b_wen = n_wen; b_d1 = n_d1; bp_bad = 0; cnt = 0;
        drive_port(1'b1, 1'b1, 1'b1, 22'h0ABCDE, 8);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = p1_grant; end
        @(posedge clk); #1;
        drive_port(1'b1, 1'b0, 1'b1, 22'h0ABCDE, 8);
        check_eq("bp_grant_seen", int'(got), 1);
        for (int i = 0; i < 40 && cnt < 3; i++) begin
            @(negedge clk);
            if (core_if.app_write_pulse) cnt++;
        end
        @(posedge clk); #1;
        core_if.write_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (p1_wr_ready || core_if.app_write_pulse) bp_bad++;
            @(posedge clk); #1;
        end
        core_if.write_fifo_full = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); got = p1_done; end
        @(posedge clk); #1;
        check_eq("bp_stalled_cycles", bp_bad, 0);
        check_eq("bp_done_count", n_d1 - b_d1, 1);
        check_eq("bp_write_pulses", n_wp - b_wp, 8);
        check_eq("bp_wen_cycles", n_wen - b_wen, 8 + 5 + DRAIN);

        // Abort: sdram_ready drops mid-read.
        @(posedge clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 22'h000200, 6);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = p0_grant; end
        @(posedge clk); #1;
        drive_port(1'b0, 1'b0, 1'b0, 22'h000200, 6);
        cnt = 0;
        for (int i = 0; i < 30 && cnt < 2; i++) begin
            @(negedge clk);
            if (p0_rd_strobe) cnt++;
        end
        check_eq("abort_strobes_before", cnt, 2);
        @(posedge clk); #1;
        core_if.sdram_ready = 1'b0;
        b_d0 = n_d0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("abort_wen", core_if.app_write_enable, 0);
        check_eq("abort_ren", core_if.app_read_enable, 0);
        check_eq("abort_grants", {p1_grant, p0_grant}, 0);
        check_eq("abort_rd_strobe", {p1_rd_strobe, p0_rd_strobe}, 0);
        check_eq("abort_read_pulse", core_if.app_read_pulse, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", n_d0 - b_d0, 0);
        core_if.sdram_ready = 1'b1;
        repeat (2) @(posedge clk);
        run_txn(6, vecs[6]);

        check_eq("protocol_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
